// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with reserve/release busy tracking.
// Reads are combinational; storage, busy bits and the busy counter are clocked.
module regfile_mp #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NREAD    = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   ctrl_reset_n,
    input  logic                   ctrl_writeEnable,
    input  logic [AW-1:0]          ctrl_writeReg,
    input  logic [WIDTH-1:0]       data_writeReg,
    input  logic                   ctrl_reserveEnable,
    input  logic [AW-1:0]          ctrl_reserveReg,
    input  logic [NREAD*AW-1:0]    ctrl_readReg,
    output logic [NREAD*WIDTH-1:0] data_readReg,
    output logic [NREAD-1:0]       data_readBusy,
    output logic [CW-1:0]          status_busyCount
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [CW-1:0]    busy_count;
    logic [CW-1:0]    count_nxt;
    logic             wr_eff;
    logic             rs_eff;
    logic             set_new;
    logic             clr_old;
    logic [AW-1:0]    rd_idx;

    // An index is live if it exists and is not the hardwired zero register.
    function automatic logic idx_valid(input logic [AW-1:0] idx);
        return ({1'b0, idx} < (AW + 1)'(DEPTH)) && !(ZERO_REG && (idx == '0));
    endfunction

    assign wr_eff = ctrl_writeEnable   && idx_valid(ctrl_writeReg);
    assign rs_eff = ctrl_reserveEnable && idx_valid(ctrl_reserveReg);

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (wr_eff && (ctrl_writeReg == AW'(r))) mem[r] <= data_writeReg;
            end
        end
    end

    // Reserve beats write on the same register: the newer producer supersedes.
    always_comb begin
        busy_nxt = busy;
        set_new  = 1'b0;
        clr_old  = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            if (rs_eff && (ctrl_reserveReg == AW'(r))) begin
                busy_nxt[r] = 1'b1;
                set_new     = !busy[r];
            end else if (wr_eff && (ctrl_writeReg == AW'(r))) begin
                busy_nxt[r] = 1'b0;
                clr_old     = busy[r];
            end
        end
        count_nxt = busy_count + CW'(set_new) - CW'(clr_old);
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= count_nxt;
        end
    end

    assign status_busyCount = busy_count;

    // Read ports; gated during reset so the bypass path cannot leak data.
    always_comb begin
        data_readReg  = '0;
        data_readBusy = '0;
        rd_idx        = '0;
        for (int p = 0; p < NREAD; p++) begin
            rd_idx = ctrl_readReg[p*AW +: AW];
            if (ctrl_reset_n && idx_valid(rd_idx)) begin
                if (BYPASS && wr_eff && (ctrl_writeReg == rd_idx)) begin
                    data_readReg[p*WIDTH +: WIDTH] = data_writeReg;
                end else begin
                    data_readReg[p*WIDTH +: WIDTH] = mem[rd_idx];
                    data_readBusy[p]               = busy[rd_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: two configurations driven in lockstep against
// an array-based reference model; a negedge monitor pops and compares expectations.
module tb_regfile_mp;

    logic        clock = 1'b0;
    logic        rst_n;

    logic        we0, re0;
    logic [4:0]  wr0, rr0;
    logic [31:0] wd0;
    logic [9:0]  rd0;
    logic [63:0] rdata0;
    logic [1:0]  rbusy0;
    logic [5:0]  cnt0;

    logic        we1, re1;
    logic [3:0]  wr1, rr1;
    logic [15:0] wd1;
    logic [11:0] rd1;
    logic [47:0] rdata1;
    logic [2:0]  rbusy1;
    logic [3:0]  cnt1;

    always #5 clock = ~clock;

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut0 (
        .clock(clock), .ctrl_reset_n(rst_n),
        .ctrl_writeEnable(we0), .ctrl_writeReg(wr0), .data_writeReg(wd0),
        .ctrl_reserveEnable(re0), .ctrl_reserveReg(rr0), .ctrl_readReg(rd0),
        .data_readReg(rdata0), .data_readBusy(rbusy0), .status_busyCount(cnt0)
    );

    regfile_mp #(.WIDTH(16), .DEPTH(12), .NREAD(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
        .clock(clock), .ctrl_reset_n(rst_n),
        .ctrl_writeEnable(we1), .ctrl_writeReg(wr1), .data_writeReg(wd1),
        .ctrl_reserveEnable(re1), .ctrl_reserveReg(rr1), .ctrl_readReg(rd1),
        .data_readReg(rdata1), .data_readBusy(rbusy1), .status_busyCount(cnt1)
    );

    typedef struct packed {
        logic            we;
        logic [4:0]      wr;
        logic [31:0]     wd;
        logic            re;
        logic [4:0]      rr;
        logic [2:0][4:0] rd;
    } stim_t;

    typedef struct packed {
        logic [2:0][31:0] data;
        logic [2:0]       busy;
        logic [5:0]       cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: plain arrays of values and busy flags per instance.
    logic [31:0] mmem  [2][32];
    bit          mbusy [2][32];

    function automatic int dep(int k);            return (k == 0) ? 32 : 12; endfunction
    function automatic bit zreg(int k);           return k == 0; endfunction
    function automatic bit byp(int k);            return k == 0; endfunction
    function automatic int nrd(int k);            return (k == 0) ? 2 : 3; endfunction
    function automatic logic [31:0] wmask(int k); return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF; endfunction

    function automatic bit eff(int k, int idx);
        return (idx < dep(k)) && !(zreg(k) && idx == 0);
    endfunction

    function automatic stim_t mk(bit we, int wr, logic [31:0] wd, bit re, int rr,
                                 int r0, int r1, int r2);
        stim_t s;
        s.we = we; s.wr = 5'(wr); s.wd = wd; s.re = re; s.rr = 5'(rr);
        s.rd[0] = 5'(r0); s.rd[1] = 5'(r1); s.rd[2] = 5'(r2);
        return s;
    endfunction

    function automatic stim_t rnd();
        return mk(bit'($urandom_range(1, 0)), int'($urandom_range(31, 0)), $urandom,
                  ($urandom_range(2, 0) == 0), int'($urandom_range(31, 0)),
                  int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
                  int'($urandom_range(31, 0)));
    endfunction

    // The 12-entry instance only sees 4-bit indices.
    function automatic stim_t norm1(stim_t s);
        stim_t t = s;
        t.wr[4] = 1'b0; t.rr[4] = 1'b0;
        for (int p = 0; p < 3; p++) t.rd[p][4] = 1'b0;
        return t;
    endfunction

    function automatic exp_t predict(int k, stim_t s);
        exp_t e;
        int   idx;
        int   n;
        e = '0;
        for (int p = 0; p < nrd(k); p++) begin
            idx = int'(s.rd[p]);
            if (eff(k, idx)) begin
                if (byp(k) && s.we && eff(k, int'(s.wr)) && int'(s.wr) == idx) begin
                    e.data[p] = s.wd & wmask(k);
                end else begin
                    e.data[p] = mmem[k][idx];
                    e.busy[p] = mbusy[k][idx];
                end
            end
        end
        n = 0;
        for (int r = 0; r < 32; r++) n += int'(mbusy[k][r]);
        e.cnt = 6'(n);
        return e;
    endfunction

    task automatic step_model(int k, stim_t s);
        if (s.we && eff(k, int'(s.wr))) begin
            mmem[k][s.wr]  = s.wd & wmask(k);
            mbusy[k][s.wr] = 1'b0;
        end
        if (s.re && eff(k, int'(s.rr))) mbusy[k][s.rr] = 1'b1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 32; r++) begin
                mmem[k][r]  = '0;
                mbusy[k][r] = 1'b0;
            end
    endtask

    task automatic drive(stim_t a, stim_t b);
        we0 = a.we; wr0 = a.wr; wd0 = a.wd; re0 = a.re; rr0 = a.rr;
        rd0 = {a.rd[1], a.rd[0]};
        we1 = b.we; wr1 = b.wr[3:0]; wd1 = b.wd[15:0]; re1 = b.re; rr1 = b.rr[3:0];
        rd1 = {b.rd[2][3:0], b.rd[1][3:0], b.rd[0][3:0]};
    endtask

    // One clock of traffic: expectation is queued before the edge, model advances on it.
    task automatic cycle(stim_t a, stim_t b_raw);
        stim_t b = norm1(b_raw);
        drive(a, b);
        q0.push_back(predict(0, a));
        q1.push_back(predict(1, b));
        @(posedge clock);
        step_model(0, a);
        step_model(1, b);
        #1;
    endtask

    // Asserts reset mid-cycle with traffic present; everything must read zero before any edge.
    task automatic reset_cycle(stim_t a, stim_t b_raw);
        stim_t b = norm1(b_raw);
        drive(a, b);
        #1;
        rst_n = 1'b0;
        clear_model();
        q0.push_back('0);
        q1.push_back('0);
        @(posedge clock);
        #1;
    endtask

    task automatic check(string name, int p, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", name, p, $time, act, exp);
        end
    endtask

    exp_t e0, e1;
    always @(negedge clock) begin
        if (q0.size() != 0) begin
            e0 = q0.pop_front();
            for (int p = 0; p < 2; p++) begin
                check("cfg0_data", p, rdata0[p*32 +: 32], e0.data[p]);
                check("cfg0_busy", p, 32'(rbusy0[p]), 32'(e0.busy[p]));
            end
            check("cfg0_count", 0, 32'(cnt0), 32'(e0.cnt));
        end
        if (q1.size() != 0) begin
            e1 = q1.pop_front();
            for (int p = 0; p < 3; p++) begin
                check("cfg1_data", p, 32'(rdata1[p*16 +: 16]), e1.data[p]);
                check("cfg1_busy", p, 32'(rbusy1[p]), 32'(e1.busy[p]));
            end
            check("cfg1_count", 0, 32'(cnt1), 32'(e1.cnt));
        end
    end

    stim_t idle;

    initial begin
        rst_n = 1'b0;
        clear_model();
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle, idle);
        repeat (2) @(posedge clock);
        #1;
        reset_cycle(idle, idle);
        rst_n = 1'b1;

        // Write r5, reserve r9, then reset mid-cycle with a bypassing write present.
        cycle(mk(1, 5, 32'hDEAD_BEEF, 1, 9, 5, 9, 0), mk(1, 5, 32'h0000_BEEF, 1, 9, 5, 9, 5));
        cycle(mk(0, 0, 0, 0, 0, 5, 9, 0), mk(0, 0, 0, 0, 0, 5, 9, 5));
        reset_cycle(mk(1, 5, 32'h1111_1111, 1, 6, 5, 9, 0), mk(1, 5, 32'h1111, 1, 6, 5, 9, 6));
        rst_n = 1'b1;
        cycle(mk(1, 6, 32'h0000_0066, 0, 0, 6, 5, 0), mk(1, 6, 32'h66, 0, 0, 6, 5, 9));
        cycle(mk(0, 0, 0, 0, 0, 6, 5, 0), mk(0, 0, 0, 0, 0, 6, 5, 9));

        // Register 0: hardwired in cfg0, ordinary in cfg1.
        cycle(mk(1, 0, 32'h1234, 1, 0, 0, 0, 0), mk(1, 0, 32'h1234, 1, 0, 0, 0, 0));
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0));

        // Same-cycle write visibility on two/three ports.
        cycle(mk(1, 7, 32'hA, 0, 0, 7, 7, 7), mk(1, 7, 32'hA, 0, 0, 7, 7, 7));
        cycle(mk(1, 7, 32'hB, 0, 0, 7, 7, 7), mk(1, 7, 32'hB, 0, 0, 7, 7, 7));
        cycle(mk(0, 0, 0, 0, 0, 7, 7, 7), mk(0, 0, 0, 0, 0, 7, 7, 7));

        // Reserve then release r3.
        cycle(mk(0, 0, 0, 1, 3, 3, 3, 3), mk(0, 0, 0, 1, 3, 3, 3, 3));
        cycle(mk(0, 0, 0, 0, 0, 3, 0, 0), mk(0, 0, 0, 0, 0, 3, 0, 0));
        cycle(mk(1, 3, 32'h33, 0, 0, 3, 0, 0), mk(1, 3, 32'h33, 0, 0, 3, 0, 0));
        cycle(mk(0, 0, 0, 0, 0, 3, 0, 0), mk(0, 0, 0, 0, 0, 3, 0, 0));

        // Simultaneous reserve and write: same register, then different registers.
        cycle(mk(0, 0, 0, 1, 3, 3, 4, 0), mk(0, 0, 0, 1, 3, 3, 4, 0));
        cycle(mk(1, 3, 32'h3C, 1, 3, 3, 4, 0), mk(1, 3, 32'h3C, 1, 3, 3, 4, 0));
        cycle(mk(0, 0, 0, 0, 0, 3, 4, 0), mk(0, 0, 0, 0, 0, 3, 4, 0));
        cycle(mk(1, 3, 32'h3D, 1, 4, 3, 4, 0), mk(1, 3, 32'h3D, 1, 4, 3, 4, 0));
        cycle(mk(0, 0, 0, 0, 0, 3, 4, 0), mk(0, 0, 0, 0, 0, 3, 4, 0));

        // Fill every register with index*0x111, read back, then probe out-of-range indices.
        for (int i = 0; i < 32; i++)
            cycle(mk(1, i, 32'(i * 32'h111), 0, 0, i, 31 - i, 0),
                  mk(1, i, 32'(i * 32'h111), 0, 0, i, 15 - (i % 16), 13));
        for (int i = 0; i < 32; i += 3)
            cycle(mk(0, 0, 0, 0, 0, i, i + 1, 0), mk(0, 0, 0, 0, 0, i, i + 1, i + 2));
        cycle(mk(0, 0, 0, 0, 0, 13, 0, 0), mk(1, 13, 32'hFFFF, 1, 13, 13, 0, 11));
        for (int i = 0; i < 16; i += 3)
            cycle(mk(0, 0, 0, 0, 0, i, i + 1, 0), mk(0, 0, 0, 0, 0, i, i + 1, i + 2));

        repeat (400) cycle(rnd(), rnd());

        drive(idle, idle);
        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with per-register busy (scoreboard) tracking, successor to the fixed 32x32 two-read-port register file. It sits in the processor decode/writeback path. It adds configurable width, depth and read-port count, an optional hardwired zero register, optional same-cycle write-to-read bypass, and a reserve/release scoreboard so decode can detect pending producers without external logic.

## Interface
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers (≥2); AW = clog2(DEPTH) is a local parameter
- NREAD, 2, number of read ports (≥1)
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes and reserves
- BYPASS, 1, 1 = a write in the current cycle is visible on matching read ports in the same cycle

Ports:
- clock  in  1  rising-edge clock
- ctrl_reset_n  in  1  asynchronous, active-low reset
- ctrl_writeEnable  in  1  write strobe
- ctrl_writeReg  in  AW  write index
- data_writeReg  in  WIDTH  write data
- ctrl_reserveEnable  in  1  mark a register busy (pending producer)
- ctrl_reserveReg  in  AW  index to reserve
- ctrl_readReg  in  NREAD*AW  packed read indices, port p at [p*AW +: AW]
- data_readReg  out  NREAD*WIDTH  packed read data, port p at [p*WIDTH +: WIDTH]
- data_readBusy  out  NREAD  per-port busy flag of the addressed register
- status_busyCount  out  clog2(DEPTH+1)  number of registers currently busy

## Operation
- Reset (ctrl_reset_n=0, asynchronous): all registers, all busy bits and status_busyCount clear to 0 immediately. During reset, data_readReg and data_readBusy are 0 for every index.
- Effective write: ctrl_writeEnable=1, ctrl_writeReg < DEPTH, and not (ZERO_REG=1 and ctrl_writeReg=0). Registers store data_writeReg at the rising edge. Ineffective writes change nothing.
- Effective reserve: ctrl_reserveEnable=1, ctrl_reserveReg < DEPTH, and not (ZERO_REG=1 and ctrl_reserveReg=0).
- Busy bit update per register r at each edge:
  - set if effective reserve targets r;
  - else cleared if effective write targets r;
  - else held.
  - Reserve wins over write to the same r in the same cycle, because the newer producer supersedes.
  - Reserving an already busy register is legal; the bit stays 1.
- Read port p, index i, combinational:
  - i ≥ DEPTH, or ZERO_REG=1 and i=0: data 0, busy 0.
  - BYPASS=1 and an effective write targets i this cycle: data = data_writeReg, busy 0.
  - otherwise: data = stored value, busy = busy bit of i.
- All read ports are independent. Any ports may address the same register.
- status_busyCount tracks the popcount of the busy bits as a registered counter:
  - +1 when a reserve sets a clear bit;
  - −1 when a write clears a set bit;
  - unchanged when reserve and write hit the same already-busy register;
  - net 0 for a reserve of one clear register plus a release of a different busy register in the same cycle.

## Timing
- Write latency: one edge. With BYPASS=0, data is visible on reads in the cycle after the edge. With BYPASS=1, data is visible in the same cycle (combinational path data_writeReg → data_readReg).
- Busy set and clear are visible on data_readBusy in the cycle after the edge. The exception is the BYPASS=1 write-match masking, which applies in the same cycle.
- status_busyCount is registered and updates on the same edge as the busy bits. It never exceeds DEPTH−ZERO_REG and never underflows.
- Reset assertion mid-cycle clears state without waiting for clock. The first write is accepted on the first rising edge after ctrl_reset_n deasserts.
- No handshake. Every request is accepted in one cycle, with no stall output.

## Test plan
- Reset then read: assert ctrl_reset_n=0 mid-cycle after writing 0xDEADBEEF to r5 → r5 reads 0 immediately and status_busyCount=0.
- Zero register: ZERO_REG=1, write 0x1234 and reserve r0 → all ports reading r0 return 0, busy 0, count 0. With ZERO_REG=0 the same write reads back 0x1234 next cycle.
- Bypass: BYPASS=1, r7=0xA, write 0xB to r7 with port0=r7 and port1=r7 in the same cycle → both ports read 0xB combinationally. With BYPASS=0 they read 0xA, then 0xB next cycle.
- Scoreboard: reserve r3 → next cycle busy=1 and count=1. Write r3 → next cycle busy=0 and count=0.
- Simultaneous events: with r3 busy, reserve r3 and write r3 in the same cycle → r3 stays busy, data updated, count stays 1. Reserve r4 and write busy r3 in the same cycle → r3 clear, r4 busy, count stays 1.
- Parameter sweep: WIDTH=16, DEPTH=12, NREAD=3, write and read every register with pattern index*0x111 → correct readback. Index 13 reads 0, and a write to index 13 alters nothing.
